ft245_if: RTL and testbench
===========================

# ft245_if

Bridges an FTDI FT245 asynchronous byte FIFO (RXF#/RD#, TXE#/WR pins) to the internal ready/acknowledge "simple interface" used by the command and data-streaming blocks. It sits directly behind the pad tri-state cells: it drives a separate output bus plus an output-enable, and samples a separate input bus. Pin timing is generated from counters derived from the clock period parameter.

## Interface
- `FT245_WIDTH`, 8: byte width of the FT245 bus and simple-interface data.
- `CLOCK_PERIOD_NS`, 10: `clk` period in ns, used to derive pin timing counts.
- `clk` input, 1: system clock; all logic on the rising edge.
- `rst` input, 1: reset, asynchronous and active-low.
- `rx_data_245` input, W: byte read from the pads.
- `rxf_245` input, 1: RXF#, low means the FT245 holds unread data.
- `rx_245` output, 1: RD#, active-low read strobe.
- `tx_data_245` output, W: byte driven to the pads.
- `txe_245` input, 1: TXE#, low means the FT245 can accept a byte.
- `wr_245` output, 1: WR strobe, active-high; the FT245 latches data on the falling edge.
- `tx_oe_245` output, 1: pad output enable; high drives the bus.
- `rx_data_si` output, W: received byte.
- `rx_rdy_si` output, 1: `rx_data_si` is valid.
- `rx_ack_si` input, 1: consumer accepts the byte.
- `tx_data_si` input, W: byte to send.
- `tx_rdy_si` input, 1: producer offers `tx_data_si`.
- `tx_ack_si` output, 1: one-cycle pulse; the byte was captured.

## Operation
- Derived counts use ceiling division, with a minimum of 1:
  - N_RD = ceil(50/P)
  - N_SU = ceil(20/P)
  - N_WR = ceil(50/P)
  - N_REC = ceil(80/P)
  - At P=10 these are 5, 2, 5 and 8.
- `rxf_245` and `txe_245` pass through S synchronizer flops before use (see Configuration).
- FSM states are IDLE, RD_ACT, RD_REC, WR_SU, WR_PULSE, WR_HOLD and WR_REC, with one shared down-counter.
- IDLE exit conditions:
  - Read candidate: synced RXF# low and `rx_rdy_si` low.
  - Write candidate: synced TXE# low and `tx_rdy_si` high.
  - If only one candidate exists, it is taken.
  - If both exist, the direction not used by the previous transfer wins. The first transfer after reset prefers read.
- Read sequence:
  - RD_ACT: `rx_245`=0 for N_RD cycles. On the last cycle, `rx_data_245` is registered into `rx_data_si` and `rx_rdy_si` is set.
  - RD_REC: `rx_245`=1 for N_REC cycles, then IDLE.
- Write sequence:
  - Entering WR_SU: `tx_data_si` is captured into `tx_data_245`, `tx_oe_245` is set, and `tx_ack_si` pulses for exactly one cycle.
  - WR_SU: N_SU cycles.
  - WR_PULSE: `wr_245`=1 for N_WR cycles.
  - WR_HOLD: `wr_245`=0, data and OE held for 1 cycle.
  - WR_REC: OE cleared, N_REC cycles, then IDLE.
- `tx_oe_245` and `rx_245`=0 are never asserted together.
- RX handshake:
  - `rx_rdy_si` stays high, with `rx_data_si` stable, until `rx_ack_si` is sampled high; it clears on the next edge.
  - `rx_ack_si` while `rx_rdy_si` is low is ignored.
  - No new read starts while `rx_rdy_si` is high.
- TX handshake: the producer must drop `tx_rdy_si` or present the next byte in the cycle after `tx_ack_si`.

## Timing
- Reset values:
  - `rx_245`=1, `wr_245`=0, `tx_oe_245`=0.
  - `tx_data_245`=0, `rx_data_si`=0.
  - `rx_rdy_si`=0, `tx_ack_si`=0.
  - FSM is in IDLE, the sync flops are 1, and the previous direction is set to "write".
- Reset asserted mid-transfer: outputs go to their reset values immediately, the bus is released, and the partial byte is discarded.
- Latency:
  - RXF# falling to `rx_245` low: S+1 edges.
  - TXE# falling, with `tx_rdy_si` already high, to `tx_ack_si`: S+1 edges.
  - Read cycle length: N_RD+N_REC; byte throughput is one per (N_RD+N_REC) cycles.
  - Write cycle length: N_SU+N_WR+1+N_REC.
- RXF#/TXE# changes during a transfer or recovery are ignored; they are re-evaluated only in IDLE.
- `rx_ack_si` arriving in the same cycle a read completes cannot occur, because the read requires `rx_rdy_si`=0.

## Configuration
- `FT245_SYNC_EN` defined: S=2, a two-flop metastability synchronizer on `rxf_245` and `txe_245`.
- `FT245_SYNC_EN` undefined: S=1, a single registered sample. This is for benches or parts where the flags are already synchronous.
- The data input is always sampled only at the end of RD_ACT and is not synchronized.

## Test plan
- Test plan parameters: P=10 with `FT245_SYNC_EN` defined.
- Reset check: assert `rst`=0 mid-write → `tx_oe_245`=0, `wr_245`=0 and `rx_245`=1 immediately; `rx_rdy_si`=0.
- Single read: drive RXF# low with bus 0xA5 → `rx_245` low 3 edges later for 5 cycles; `rx_rdy_si`=1 with `rx_data_si`=0xA5. Pulse `rx_ack_si` → `rx_rdy_si`=0 next cycle.
- RX backpressure: RXF# held low and no ack → exactly one `rx_245` pulse. Ack → the next read starts after recovery completes.
- Single write: TXE# low, `tx_rdy_si`=1 with 0x3C → one-cycle `tx_ack_si`; `tx_data_245`=0x3C with OE for 2 cycles before `wr_245` rises; `wr_245` high 5 cycles; OE held 1 cycle after the fall.
- Contention: RXF# and TXE# both low with TX pending → transfers alternate read, write, read. `tx_oe_245` is never high while `rx_245`=0.
- TXE# high: `tx_rdy_si`=1 with TXE# high → no `tx_ack_si` and `wr_245` stays 0 until TXE# falls.

Source files
------------

// File: rtl/ft245_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : ft245_if_if
//  Description : Pad-side FT245 pins plus the internal ready/ack simple
//                interface, bundled for the ft245_if bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ft245_if_if #(
    parameter int FT245_WIDTH = 8
);
    logic [FT245_WIDTH-1:0] rx_data_245;
    logic                   rxf_245;
    logic                   rx_245;
    logic [FT245_WIDTH-1:0] tx_data_245;
    logic                   txe_245;
    logic                   wr_245;
    logic                   tx_oe_245;
    logic [FT245_WIDTH-1:0] rx_data_si;
    logic                   rx_rdy_si;
    logic                   rx_ack_si;
    logic [FT245_WIDTH-1:0] tx_data_si;
    logic                   tx_rdy_si;
    logic                   tx_ack_si;

    // Bridge view
    modport master (
        input  rx_data_245, rxf_245, txe_245, rx_ack_si, tx_data_si, tx_rdy_si,
        output rx_245, tx_data_245, wr_245, tx_oe_245, rx_data_si, rx_rdy_si, tx_ack_si
    );

    // Pad / consumer / producer view
    modport slave (
        output rx_data_245, rxf_245, txe_245, rx_ack_si, tx_data_si, tx_rdy_si,
        input  rx_245, tx_data_245, wr_245, tx_oe_245, rx_data_si, rx_rdy_si, tx_ack_si
    );
endinterface
`default_nettype wire

// File: rtl/ft245_if.sv
`default_nettype none
// ============================================================================
//  Module      : ft245_if
//  Description : FT245 async FIFO to ready/ack simple-interface bridge.
//                Define FT245_SYNC_EN for a two-flop RXF#/TXE# synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ft245_if #(
    parameter int FT245_WIDTH     = 8,
    parameter int CLOCK_PERIOD_NS = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ft245_if_if.master     bus
);
    function automatic int f_cycles(input int ns);
        int n;
        n = (ns + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
        return (n < 1) ? 1 : n;
    endfunction

    localparam logic [15:0] c_n_rd  = 16'(f_cycles(50));
    localparam logic [15:0] c_n_su  = 16'(f_cycles(20));
    localparam logic [15:0] c_n_wr  = 16'(f_cycles(50));
    localparam logic [15:0] c_n_rec = 16'(f_cycles(80));

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_rd_act   = 3'd1;
    localparam logic [2:0] c_st_rd_rec   = 3'd2;
    localparam logic [2:0] c_st_wr_su    = 3'd3;
    localparam logic [2:0] c_st_wr_pulse = 3'd4;
    localparam logic [2:0] c_st_wr_hold  = 3'd5;
    localparam logic [2:0] c_st_wr_rec   = 3'd6;

    logic [2:0]             r_state;
    logic [15:0]            r_cnt;
    logic                   r_last_wr;
    logic                   r_rxf_sync;
    logic                   r_txe_sync;
    logic                   r_rd_n;
    logic                   r_wr;
    logic                   r_oe;
    logic                   r_tx_ack;
    logic                   r_rx_rdy;
    logic [FT245_WIDTH-1:0] r_tx_data;
    logic [FT245_WIDTH-1:0] r_rx_data;

    logic w_cand_rd;
    logic w_cand_wr;
    logic w_pick_rd;
    logic w_pick_wr;

`ifdef FT245_SYNC_EN
    logic r_rxf_meta;
    logic r_txe_meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxf_meta <= 1'b1;
            r_txe_meta <= 1'b1;
            r_rxf_sync <= 1'b1;
            r_txe_sync <= 1'b1;
        end else begin
            r_rxf_meta <= bus.rxf_245;
            r_txe_meta <= bus.txe_245;
            r_rxf_sync <= r_rxf_meta;
            r_txe_sync <= r_txe_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxf_sync <= 1'b1;
            r_txe_sync <= 1'b1;
        end else begin
            r_rxf_sync <= bus.rxf_245;
            r_txe_sync <= bus.txe_245;
        end
    end
`endif

    // When both directions are ready, alternate away from the last transfer.
    assign w_cand_rd = !r_rxf_sync && !r_rx_rdy;
    assign w_cand_wr = !r_txe_sync && bus.tx_rdy_si;
    assign w_pick_rd = w_cand_rd && (!w_cand_wr || r_last_wr);
    assign w_pick_wr = w_cand_wr && !w_pick_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= 16'd0;
            r_last_wr <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr      <= 1'b0;
            r_oe      <= 1'b0;
            r_tx_ack  <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_tx_data <= '0;
            r_rx_data <= '0;
        end else begin
            r_tx_ack <= 1'b0;
            if (r_rx_rdy && bus.rx_ack_si)
                r_rx_rdy <= 1'b0;

            case (r_state)
                // The final recovery cycle doubles as the idle decision so
                // back-to-back transfers run without a bubble.
                c_st_idle, c_st_rd_rec, c_st_wr_rec: begin
                    if (r_state == c_st_idle || r_cnt == 16'd0) begin
                        if (w_pick_rd) begin
                            r_state   <= c_st_rd_act;
                            r_rd_n    <= 1'b0;
                            r_cnt     <= c_n_rd - 16'd1;
                            r_last_wr <= 1'b0;
                        end else if (w_pick_wr) begin
                            r_state   <= c_st_wr_su;
                            r_tx_data <= bus.tx_data_si;
                            r_oe      <= 1'b1;
                            r_tx_ack  <= 1'b1;
                            r_cnt     <= c_n_su - 16'd1;
                            r_last_wr <= 1'b1;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_st_rd_act: begin
                    if (r_cnt == 16'd0) begin
                        r_rd_n    <= 1'b1;
                        r_rx_data <= bus.rx_data_245;
                        r_rx_rdy  <= 1'b1;
                        r_state   <= c_st_rd_rec;
                        r_cnt     <= c_n_rec - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_st_wr_su: begin
                    if (r_cnt == 16'd0) begin
                        r_wr    <= 1'b1;
                        r_state <= c_st_wr_pulse;
                        r_cnt   <= c_n_wr - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_st_wr_pulse: begin
                    if (r_cnt == 16'd0) begin
                        r_wr    <= 1'b0;
                        r_state <= c_st_wr_hold;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_st_wr_hold: begin
                    r_oe    <= 1'b0;
                    r_state <= c_st_wr_rec;
                    r_cnt   <= c_n_rec - 16'd1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.rx_245      = r_rd_n;
    assign bus.wr_245      = r_wr;
    assign bus.tx_oe_245   = r_oe;
    assign bus.tx_data_245 = r_tx_data;
    assign bus.rx_data_si  = r_rx_data;
    assign bus.rx_rdy_si   = r_rx_rdy;
    assign bus.tx_ack_si   = r_tx_ack;
endmodule
`default_nettype wire

// File: tb/tb_ft245_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ft245_if
//  Description : Self-checking bench for ft245_if (S follows FT245_SYNC_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ft245_if;
    localparam int W = 8;
    localparam int P = 10;
`ifdef FT245_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    // Pin timing at 10 ns: ceil(50/10), ceil(20/10), ceil(50/10), ceil(80/10)
    localparam int N_RD   = 5;
    localparam int N_SU   = 2;
    localparam int N_WR   = 5;
    localparam int N_REC  = 8;
    localparam int RD_LEN = N_RD + N_REC;
    localparam int WR_LEN = N_SU + N_WR + 1 + N_REC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic auto_ack = 1'b0;

    ft245_if_if #(.FT245_WIDTH(W)) bus();
    ft245_if #(.FT245_WIDTH(W), .CLOCK_PERIOD_NS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-timeline model: a transfer is a start edge plus a kind,
    // and every pin is a function of the offset from that start.
    int        cyc = 0;
    int        m_start = 0;
    int        m_next = 0;
    bit        m_busy = 1'b0;
    bit        m_wr = 1'b0;
    bit        m_last_wr = 1'b1;
    bit        m_rdy = 1'b0;
    logic [W-1:0] m_rxd = '0;
    logic [W-1:0] m_txd = '0;
    logic      h_rxf [S];
    logic      h_txe [S];

    always @(posedge clk) begin
        logic s_rxf, s_txe, old_rdy, can_rd, can_wr;
        cyc++;
        if (!rst) begin
            for (int i = 0; i < S; i++) begin
                h_rxf[i] = 1'b1;
                h_txe[i] = 1'b1;
            end
            m_busy = 1'b0; m_next = 0; m_last_wr = 1'b1;
            m_rdy = 1'b0; m_rxd = '0; m_txd = '0;
        end else begin
            s_rxf = h_rxf[S-1];
            s_txe = h_txe[S-1];
            for (int i = S - 1; i > 0; i--) begin
                h_rxf[i] = h_rxf[i-1];
                h_txe[i] = h_txe[i-1];
            end
            h_rxf[0] = bus.rxf_245;
            h_txe[0] = bus.txe_245;
            old_rdy = m_rdy;
            if (m_busy && !m_wr && cyc == m_start + N_RD) begin
                m_rdy = 1'b1;
                m_rxd = bus.rx_data_245;
            end
            if (old_rdy && bus.rx_ack_si === 1'b1)
                m_rdy = 1'b0;
            if (cyc >= m_next) begin
                can_rd = !s_rxf && !old_rdy;
                can_wr = !s_txe && bus.tx_rdy_si;
                if (can_rd || can_wr) begin
                    m_wr      = can_wr && (!can_rd || !m_last_wr);
                    m_last_wr = m_wr;
                    m_busy    = 1'b1;
                    m_start   = cyc;
                    m_next    = cyc + (m_wr ? WR_LEN : RD_LEN);
                    if (m_wr) m_txd = bus.tx_data_si;
                end
            end
        end
    end

    // Per-cycle compare plus an event monitor for the directed checks.
    int n_rd = 0, n_rdy = 0, n_ack = 0, n_wrr = 0, n_wrf = 0;
    int t_rx_fall = 0, t_rx_rise = 0, t_ack = 0, t_ack_fall = 0;
    int t_wr_rise = 0, t_wr_fall = 0, t_oe_rise = 0, t_oe_fall = 0;
    logic p_rx = 1'b1, p_ack = 1'b0, p_wr = 1'b0, p_oe = 1'b0, p_rdy = 1'b0;
    int   dirq [$];

    always @(negedge clk) begin
        int off;
        bit in_rd, in_wr;
        if (rst) begin
            off   = cyc - m_start;
            in_rd = m_busy && !m_wr && off < RD_LEN;
            in_wr = m_busy && m_wr && off < WR_LEN;
            chk("rx_245",      bus.rx_245,      32'(!(in_rd && off < N_RD)));
            chk("wr_245",      bus.wr_245,      32'(in_wr && off >= N_SU && off < N_SU + N_WR));
            chk("tx_oe_245",   bus.tx_oe_245,   32'(in_wr && off < N_SU + N_WR + 1));
            chk("tx_ack_si",   bus.tx_ack_si,   32'(in_wr && off == 0));
            chk("tx_data_245", bus.tx_data_245, 32'(m_txd));
            chk("rx_rdy_si",   bus.rx_rdy_si,   32'(m_rdy));
            chk("rx_data_si",  bus.rx_data_si,  32'(m_rxd));
            chk("oe_vs_rd",    bus.tx_oe_245 & ~bus.rx_245, 32'd0);
        end
        if (p_rx && !bus.rx_245)     begin n_rd++;  t_rx_fall = cyc; dirq.push_back(0); end
        if (!p_rx && bus.rx_245)     t_rx_rise = cyc;
        if (!p_rdy && bus.rx_rdy_si) n_rdy++;
        if (!p_ack && bus.tx_ack_si) begin n_ack++; t_ack = cyc; dirq.push_back(1); end
        if (p_ack && !bus.tx_ack_si) t_ack_fall = cyc;
        if (!p_wr && bus.wr_245)     begin n_wrr++; t_wr_rise = cyc; end
        if (p_wr && !bus.wr_245)     begin n_wrf++; t_wr_fall = cyc; end
        if (!p_oe && bus.tx_oe_245)  t_oe_rise = cyc;
        if (p_oe && !bus.tx_oe_245)  t_oe_fall = cyc;
        p_rx = bus.rx_245; p_ack = bus.tx_ack_si; p_wr = bus.wr_245;
        p_oe = bus.tx_oe_245; p_rdy = bus.rx_rdy_si;
    end

    always @(negedge clk) begin
        #2;
        bus.rx_ack_si = auto_ack & bus.rx_rdy_si;
    end

    function automatic int cnt_of(input int which);
        case (which)
            0:       return n_rd;
            1:       return n_rdy;
            2:       return n_ack;
            3:       return n_wrr;
            default: return n_wrf;
        endcase
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input string nm, input int which, input int base);
        int k;
        k = 0;
        while (cnt_of(which) <= base && k < 60) begin
            tick(1);
            k++;
        end
        chk(nm, 32'(cnt_of(which) > base), 32'd1);
    endtask

    initial begin
        int t0, t2, b;
        bus.rxf_245 = 1'b1; bus.txe_245 = 1'b1; bus.rx_data_245 = '0;
        bus.tx_data_si = '0; bus.tx_rdy_si = 1'b0;
        tick(3);
        chk("rst_rx_245",  bus.rx_245,      32'd1);
        chk("rst_wr_245",  bus.wr_245,      32'd0);
        chk("rst_oe",      bus.tx_oe_245,   32'd0);
        chk("rst_tx_data", bus.tx_data_245, 32'd0);
        chk("rst_rx_data", bus.rx_data_si,  32'd0);
        chk("rst_rx_rdy",  bus.rx_rdy_si,   32'd0);
        chk("rst_tx_ack",  bus.tx_ack_si,   32'd0);
        rst = 1'b1;
        tick(3);

        // Single read, then backpressure with the byte left unacknowledged
        bus.rx_data_245 = 8'hA5; bus.rxf_245 = 1'b0; t0 = cyc; b = n_rd;
        wait_cnt("rd_start", 0, b);
        chk("rd_latency", 32'(t_rx_fall - t0), 32'(S + 1));
        wait_cnt("rd_done", 1, 0);
        chk("rd_width", 32'(t_rx_rise - t_rx_fall), 32'd5);
        chk("rd_data_a5", bus.rx_data_si, 32'hA5);
        tick(30);
        chk("rd_backpressure", 32'(n_rd - b), 32'd1);
        bus.rx_data_245 = 8'h5A; auto_ack = 1'b1; t0 = cyc;
        tick(1);
        chk("rdy_clear", bus.rx_rdy_si, 32'd0);
        wait_cnt("rd2_start", 0, b + 1);
        chk("rd_after_ack", 32'(t_rx_fall - t0), 32'd2);
        t2 = t_rx_fall;
        wait_cnt("rd3_start", 0, b + 2);
        chk("rd_throughput", 32'(t_rx_fall - t2), 32'd13);
        bus.rxf_245 = 1'b1;
        tick(20);
        chk("rd_data_5a", bus.rx_data_si, 32'h5A);

        // Write held off by TXE#, then a single write
        bus.tx_data_si = 8'h3C; bus.tx_rdy_si = 1'b1; b = n_ack;
        tick(8);
        chk("no_ack_txe_high", 32'(n_ack - b), 32'd0);
        chk("no_wr_txe_high", 32'(n_wrr), 32'd0);
        bus.txe_245 = 1'b0; t0 = cyc;
        wait_cnt("wr_ack", 2, b);
        chk("wr_latency", 32'(t_ack - t0), 32'(S + 1));
        bus.tx_rdy_si = 1'b0;
        chk("wr_data_3c", bus.tx_data_245, 32'h3C);
        wait_cnt("wr_fall", 4, 0);
        tick(2);
        bus.txe_245 = 1'b1;
        chk("ack_width", 32'(t_ack_fall - t_ack), 32'd1);
        chk("oe_setup", 32'(t_wr_rise - t_oe_rise), 32'd2);
        chk("wr_width", 32'(t_wr_fall - t_wr_rise), 32'd5);
        chk("oe_hold", 32'(t_oe_fall - t_wr_fall), 32'd1);
        tick(20);

        // Contention: both flags low with TX pending
        dirq.delete();
        bus.tx_data_si = 8'h81; bus.tx_rdy_si = 1'b1;
        bus.rxf_245 = 1'b0; bus.txe_245 = 1'b0;
        tick(50);
        bus.rxf_245 = 1'b1; bus.tx_rdy_si = 1'b0;
        tick(20);
        bus.txe_245 = 1'b1;
        chk("alt_count", 32'(dirq.size() >= 3), 32'd1);
        if (dirq.size() >= 3) begin
            chk("alt_0_read",  32'(dirq[0]), 32'd0);
            chk("alt_1_write", 32'(dirq[1]), 32'd1);
            chk("alt_2_read",  32'(dirq[2]), 32'd0);
        end

        // Reset in the middle of a write with a received byte pending
        auto_ack = 1'b0; bus.rx_data_245 = 8'h66; bus.rxf_245 = 1'b0; b = n_rdy;
        wait_cnt("pend_rd", 1, b);
        bus.rxf_245 = 1'b1;
        bus.tx_data_si = 8'h99; bus.tx_rdy_si = 1'b1; bus.txe_245 = 1'b0; b = n_wrr;
        wait_cnt("pend_wr", 3, b);
        tick(1);
        rst = 1'b0;
        #1;
        chk("mid_rst_oe",  bus.tx_oe_245, 32'd0);
        chk("mid_rst_wr",  bus.wr_245,    32'd0);
        chk("mid_rst_rd",  bus.rx_245,    32'd1);
        chk("mid_rst_rdy", bus.rx_rdy_si, 32'd0);
        tick(2);
        bus.txe_245 = 1'b1; bus.tx_rdy_si = 1'b0;
        rst = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
`default_nettype wire
